// File: rtl/ucy_vram_arbiter.sv
// Shares one asynchronous VRAM between the video character fetch and the Z80.
// The video owns a fixed phase slot each character period; CPU accesses fill free slots.
`timescale 1ns / 1ps

module ucy_vram_arbiter #(
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned FETCH_PERIOD = 8,
    parameter int unsigned FETCH_SLOT   = 0
) (
    input  logic              clk,
    input  logic              nr,
    input  logic              cpu_nreq,
    input  logic              cpu_nwr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_nwait,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_strobe,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_nwe,
    output logic              ram_noe,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned PhW = (FETCH_PERIOD > 1) ? $clog2(FETCH_PERIOD) : 1;
    localparam logic [PhW-1:0] LastPh = PhW'(FETCH_PERIOD - 1);
    localparam logic [PhW-1:0] SlotPh = PhW'(FETCH_SLOT);

    typedef enum logic [1:0] {StIdle, StPend, StAcc, StDone} state_e;

    state_e            state_q;
    logic [PhW-1:0]    phase_q;
    logic [PhW-1:0]    phase_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              nwr_q;
    logic              fetch;

    assign phase_d = (phase_q == LastPh) ? '0 : phase_q + PhW'(1);
    assign fetch   = nr && (phase_q == SlotPh);

    always_ff @(posedge clk) begin
        if (!nr) begin
            phase_q    <= '0;
            state_q    <= StIdle;
            cpu_nwait  <= 1'b1;
            cpu_rdata  <= '0;
            vid_data   <= '0;
            vid_strobe <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            nwr_q      <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            vid_strobe <= fetch;
            if (fetch) begin
                vid_data <= ram_rdata;
            end
            unique case (state_q)
                StIdle: begin
                    if (!cpu_nreq) begin
                        addr_q    <= cpu_addr;
                        wdata_q   <= cpu_wdata;
                        nwr_q     <= cpu_nwr;
                        cpu_nwait <= 1'b0;
                        state_q   <= StPend;
                    end
                end
                StPend: begin
                    // Defer one cycle when the next phase belongs to the video fetch.
                    if (cpu_nreq) begin
                        cpu_nwait <= 1'b1;
                        state_q   <= StIdle;
                    end else if (phase_d != SlotPh) begin
                        state_q <= StAcc;
                    end
                end
                StAcc: begin
                    if (nwr_q) begin
                        cpu_rdata <= ram_rdata;
                    end
                    cpu_nwait <= 1'b1;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (cpu_nreq) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        ram_noe   = 1'b1;
        ram_nwe   = 1'b1;
        if (!nr) begin
            ram_addr  = '0;
            ram_wdata = '0;
        end else if (fetch) begin
            ram_addr = vid_addr;
            ram_noe  = 1'b0;
        end else if (state_q == StAcc) begin
            if (nwr_q) begin
                ram_noe = 1'b0;
            end else begin
                ram_nwe = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ucy_vram_arbiter.sv
// Scoreboard bench for ucy_vram_arbiter: directed CPU accesses against a VRAM model,
// with a negedge monitor checking fetch slots, CPU bus cycles and WAIT timing.
`timescale 1ns / 1ps

module tb_ucy_vram_arbiter;

    localparam logic [10:0] VidA = 11'h123;

    logic        clk = 1'b0;
    logic        nr = 1'b0;
    logic        cpu_nreq = 1'b1;
    logic        cpu_nwr = 1'b1;
    logic [10:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_nwait;
    logic [7:0]  cpu_rdata;
    logic [10:0] vid_addr = VidA;
    logic [7:0]  vid_data;
    logic        vid_strobe;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_nwe;
    logic        ram_noe;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [0:2047];

    int unsigned checks = 0;
    int unsigned failures = 0;

    ucy_vram_arbiter #(
        .ADDR_W(11), .DATA_W(8), .FETCH_PERIOD(8), .FETCH_SLOT(0)
    ) dut (
        .clk(clk), .nr(nr), .cpu_nreq(cpu_nreq), .cpu_nwr(cpu_nwr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_nwait(cpu_nwait),
        .cpu_rdata(cpu_rdata), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_strobe(vid_strobe), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_nwe(ram_nwe), .ram_noe(ram_noe), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (!ram_nwe) mem[ram_addr] <= ram_wdata;
    end

    // Reference phase: reset to 0, then counts modulo 8.
    int unsigned tb_phase = 0;
    always @(posedge clk) begin
        if (!nr) tb_phase <= 0;
        else     tb_phase <= (tb_phase == 7) ? 0 : tb_phase + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        we;
        logic [10:0] addr;
        logic [7:0]  wdata;
        int unsigned phase;
    } acc_t;

    typedef struct {
        logic        rd;
        logic [7:0]  rdata;
        int unsigned waits;
    } done_t;

    typedef struct {
        int unsigned ph;
        logic        we;
        logic [10:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int unsigned acc_ph;
        int unsigned waits;
        int unsigned hold;
    } vec_t;

    acc_t  acc_q[$];
    done_t done_q[$];

    // Monitor
    logic        mon_en = 1'b0;
    logic        fetch_prev = 1'b0;
    logic        prev_nr = 1'b0;
    logic        prev_nwait = 1'b1;
    int unsigned wait_cnt = 0;
    acc_t        a;
    done_t       d;

    always @(negedge clk) begin
        if (mon_en) begin
            if (nr && tb_phase == 0) begin
                chk("fetch_addr", 32'(ram_addr), 32'(VidA));
                chk("fetch_noe", 32'(ram_noe), 32'd0);
                chk("fetch_nwe", 32'(ram_nwe), 32'd1);
            end
            chk("vid_strobe", 32'(vid_strobe), 32'(fetch_prev));
            if (vid_strobe) chk("vid_data", 32'(vid_data), 32'h41);
            if (nr && tb_phase != 0 && (!ram_noe || !ram_nwe)) begin
                if (acc_q.size() == 0) begin
                    chk("unexpected_access", 32'd1, 32'd0);
                end else begin
                    a = acc_q.pop_front();
                    chk("acc_we", 32'(!ram_nwe), 32'(a.we));
                    chk("acc_addr", 32'(ram_addr), 32'(a.addr));
                    chk("acc_phase", tb_phase, a.phase);
                    if (a.we) begin
                        chk("acc_wdata", 32'(ram_wdata), 32'(a.wdata));
                        chk("acc_noe_on_write", 32'(ram_noe), 32'd1);
                    end
                end
            end
            if (!nr) begin
                wait_cnt = 0;
            end else if (!cpu_nwait) begin
                wait_cnt++;
            end else if (prev_nr && !prev_nwait) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    d = done_q.pop_front();
                    chk("wait_cycles", wait_cnt, d.waits);
                    if (d.rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(d.rdata));
                end
                wait_cnt = 0;
            end
        end
        fetch_prev = nr && (tb_phase == 0);
        prev_nr    = nr;
        prev_nwait = cpu_nwait;
    end

    task automatic do_access(input vec_t v);
        logic done_ok;
        for (int i = 0; i < 8 && tb_phase != v.ph; i++) begin
            @(posedge clk); #1;
        end
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        cpu_nwr   = !v.we;
        cpu_nreq  = 1'b0;
        acc_q.push_back('{we: v.we, addr: v.addr, wdata: v.wdata, phase: v.acc_ph});
        done_q.push_back('{rd: !v.we, rdata: v.rdata, waits: v.waits});
        done_ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i > 0 && cpu_nwait) begin
                done_ok = 1'b1;
                break;
            end
        end
        if (!done_ok) chk("nwait_timeout", 32'd0, 32'd1);
        for (int i = 0; i < int'(v.hold); i++) begin
            @(posedge clk); #1;
            chk("held_nwait", 32'(cpu_nwait), 32'd1);
        end
        cpu_nreq = 1'b1;
        cpu_nwr  = 1'b1;
        @(posedge clk); #1;
    endtask

    // Start a write at phase ph, then reset after k further clock edges.
    task automatic reset_during(input int unsigned ph, input int unsigned k);
        for (int i = 0; i < 8 && tb_phase != ph; i++) begin
            @(posedge clk); #1;
        end
        cpu_addr  = 11'h040;
        cpu_wdata = 8'h77;
        cpu_nwr   = 1'b0;
        cpu_nreq  = 1'b0;
        repeat (k) @(posedge clk);
        #1;
        nr       = 1'b0;
        cpu_nreq = 1'b1;
        cpu_nwr  = 1'b1;
        @(negedge clk);
        chk("rst_cycle_nwe", 32'(ram_nwe), 32'd1);
        chk("rst_cycle_noe", 32'(ram_noe), 32'd1);
        @(posedge clk); #1;
        nr = 1'b1;
        chk("rst_after_nwait", 32'(cpu_nwait), 32'd1);
        @(posedge clk); #1;
        chk("rst_idle_nwait", 32'(cpu_nwait), 32'd1);
        chk("rst_no_write", 32'(mem[11'h040]), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        mem[11'h123] = 8'h41;
        mem[11'h010] = 8'h5A;

        //          ph we addr     wdata  rdata  acc waits hold
        vecs[0] = '{2, 0, 11'h010, 8'h00, 8'h5A, 4, 2, 0};
        vecs[1] = '{6, 1, 11'h020, 8'hC3, 8'h00, 1, 3, 0};
        vecs[2] = '{3, 0, 11'h020, 8'h00, 8'hC3, 5, 2, 0};
        vecs[3] = '{5, 1, 11'h030, 8'h99, 8'h00, 7, 2, 10};
        vecs[4] = '{7, 0, 11'h030, 8'h00, 8'h99, 1, 2, 0};
        vecs[5] = '{6, 0, 11'h010, 8'h00, 8'h5A, 1, 3, 0};
        vecs[6] = '{2, 0, 11'h010, 8'h00, 8'h5A, 4, 2, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_nwait", 32'(cpu_nwait), 32'd1);
        chk("reset_rdata", 32'(cpu_rdata), 32'd0);
        chk("reset_vid_data", 32'(vid_data), 32'd0);
        chk("reset_strobe", 32'(vid_strobe), 32'd0);
        chk("reset_noe", 32'(ram_noe), 32'd1);
        chk("reset_nwe", 32'(ram_nwe), 32'd1);
        chk("reset_addr", 32'(ram_addr), 32'd0);
        chk("reset_wdata", 32'(ram_wdata), 32'd0);
        @(posedge clk); #1;
        nr     = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) do_access(vecs[i]);
        reset_during(2, 2);
        reset_during(2, 1);
        do_access(vecs[6]);

        repeat (10) @(posedge clk);
        #1;
        chk("acc_q_drained", acc_q.size(), 32'd0);
        chk("done_q_drained", done_q.size(), 32'd0);
        chk("mem_write_020", 32'(mem[11'h020]), 32'hC3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ucy_vram_arbiter.md
Name: ucy_vram_arbiter

Overview:
Sequences a shared asynchronous video RAM between the Z80 CPU and the character fetch of the video timing chain.
- Video fetch has absolute priority and owns one fixed slot per character period.
- CPU accesses are inserted into free slots. The CPU is stalled through an active-low WAIT until its access has completed.
- Sits between the CPU address decode, the video counters and the VRAM chip pins.

Parameters:
ADDR_W, 11, VRAM address width
DATA_W, 8, VRAM data width
FETCH_PERIOD, 8, clocks per character cell; legal range >= 2
FETCH_SLOT, 0, phase index reserved for the video fetch; legal range 0..FETCH_PERIOD-1

Ports:
clk  input  1  system clock, all state updates on posedge
nr  input  1  reset, synchronous, active-low
cpu_nreq  input  1  active-low CPU VRAM request (MREQ and address decode combined)
cpu_nwr  input  1  active-low write qualifier, sampled with the request
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_nwait  output  1  active-low WAIT to the Z80, registered
cpu_rdata  output  DATA_W  CPU read data, registered, held until the next CPU read
vid_addr  input  ADDR_W  character address from the video counters
vid_data  output  DATA_W  fetched character byte, registered
vid_strobe  output  1  one-cycle pulse marking a vid_data update
ram_addr  output  ADDR_W  VRAM address
ram_wdata  output  DATA_W  VRAM write data
ram_nwe  output  1  VRAM write enable, active-low
ram_noe  output  1  VRAM output enable, active-low
ram_rdata  input  DATA_W  VRAM read data, valid combinationally within the cycle

Behaviour:
- Reset (nr low at posedge):
  - phase=0, state=IDLE, cpu_nwait=1, cpu_rdata=0, vid_data=0, vid_strobe=0, latched request regs=0.
  - While nr is low: ram_noe=1, ram_nwe=1, ram_addr=0, ram_wdata=0.
  - Reset mid-access aborts the access with no write; cpu_nwait is 1 on the first cycle after reset.
- Phase counter: increments every cycle and wraps FETCH_PERIOD-1 -> 0.
- Video fetch cycle (phase==FETCH_SLOT, out of reset):
  - ram_addr=vid_addr, ram_noe=0, ram_nwe=1.
  - vid_data<=ram_rdata at the end of the cycle; vid_strobe=1 in the following cycle only.
- RAM bus ownership is combinational from phase and state:
  - fetch cycle -> video;
  - else state ACC -> CPU;
  - else idle (ram_noe=ram_nwe=1, ram_addr=latched CPU address).
  - ACC never coincides with the fetch cycle.
- CPU FSM states: IDLE, PEND, ACC, DONE.
  - IDLE: if cpu_nreq=0, latch cpu_addr, cpu_wdata and cpu_nwr; cpu_nwait<=0; go to PEND. Otherwise stay.
  - PEND: if cpu_nreq=1, abort to IDLE with cpu_nwait<=1. Else if ((phase+1) mod FETCH_PERIOD) != FETCH_SLOT, go to ACC. Else stay in PEND (exactly one deferral cycle).
  - ACC:
    - read: ram_noe=0, and cpu_rdata<=ram_rdata at the end of the cycle;
    - write: ram_nwe=0, ram_wdata=latched data, ram_noe=1;
    - in both cases cpu_nwait<=1 and the next state is DONE.
    - ACC always completes, even if cpu_nreq has risen.
  - DONE: RAM idle. Hold until cpu_nreq=1, then go to IDLE. A request still asserted never causes a second access.
- Latency:
  - request sampled at cycle N -> ACC at N+2 (N+3 if deferred) -> cpu_nwait high from N+3 (N+4).
  - cpu_nwait is low for 2 cycles nominal, 3 worst case.
- Simultaneous events: a fetch slot during PEND or DONE never stalls the video. The video is never delayed by the CPU.

Test Plan:
1. Reset with nr=0 for 3 cycles -> all outputs at reset values, ram_noe=ram_nwe=1. After release, the first fetch occurs at phase 0 with vid_strobe=1 one cycle later.
2. Video fetch: ram model holds 0x41 at vid_addr=0x123 -> during the fetch cycle ram_addr=0x123 and ram_noe=0. Next cycle vid_data=0x41 and vid_strobe=1 for exactly 1 cycle. This repeats every 8 cycles.
3. CPU read, non-colliding: cpu_nreq=0 at phase 2, cpu_addr=0x010, RAM[0x010]=0x5A -> ACC at phase 4; cpu_nwait low for 2 cycles, then high with cpu_rdata=0x5A.
4. CPU write colliding: cpu_nreq=0, cpu_nwr=0 at phase 6, wdata=0xC3 -> PEND defers one cycle and the fetch at phase 0 is unaffected. ACC at phase 1 with ram_nwe=0 and ram_addr=cpu_addr; cpu_nwait low for 3 cycles.
5. Held request: cpu_nreq kept low for 10 cycles after completion -> exactly one ram_nwe pulse and cpu_nwait stays 1. After cpu_nreq=1 then 0, a new access occurs.
6. Reset during PEND and during ACC of a write -> no ram_nwe=0 in the reset cycle; cpu_nwait=1 and state IDLE on the next cycle.
